// File: rtl/prbs_train_lane_tx.sv
// Fabric-side TX source for the DDRX4 IOD lanes: training pattern until the far end
// reports bit alignment, then PRBS7 (x^7+x^6+1) with optional single-bit error injection.
module prbs_train_lane_tx #(
  parameter int unsigned      LANES           = 2,
  parameter int unsigned      RATIO           = 8,
  parameter logic [RATIO-1:0] TRAIN_PATTERN   = 8'hF0,
  parameter int unsigned      TRAIN_MIN_WORDS = 256,
  parameter int unsigned      TRAIN_TIMEOUT   = 4095,
  parameter logic [6:0]       PRBS_SEED       = 7'h7F
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     ALGN_DONE,
  input  logic                     ALGN_ERR,
  input  logic                     INJ_ERR,
  output logic [LANES*RATIO-1:0]   TXD_DATA,
  output logic                     TX_VALID,
  output logic [1:0]               STATE,
  output logic [15:0]              TRAIN_CNT,
  output logic [7:0]               ERR_INJ_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    PRBS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [15:0] MIN_M1   = 16'(TRAIN_MIN_WORDS - 1);
  localparam logic [15:0] TIMEOUT  = 16'(TRAIN_TIMEOUT);

  state_t                   state;
  logic [6:0]               lfsr;
  logic [6:0]               prbs_src;
  logic [6:0]               prbs_next;
  logic [RATIO-1:0]         prbs_word;
  logic [LANES*RATIO-1:0]   inj_mask;

  assign STATE    = state;
  assign inj_mask = {{(LANES*RATIO-1){1'b0}}, INJ_ERR};

  // The entry word is generated straight from the seed so the first PRBS word
  // appears on the same edge that STATE becomes PRBS.
  always_comb begin
    prbs_src  = (state == PRBS) ? lfsr : PRBS_SEED;
    prbs_next = prbs_src;
    prbs_word = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      prbs_word[k] = prbs_next[6] ^ prbs_next[5];
      prbs_next    = {prbs_next[5:0], prbs_word[k]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      TXD_DATA    <= '0;
      TX_VALID    <= 1'b0;
      TRAIN_CNT   <= '0;
      ERR_INJ_CNT <= '0;
      lfsr        <= PRBS_SEED;
    end else begin
      if ((state == PRBS) && INJ_ERR && (ERR_INJ_CNT != 8'hFF))
        ERR_INJ_CNT <= ERR_INJ_CNT + 8'd1;

      unique case (state)
        IDLE: begin
          if (START) begin
            state     <= TRAIN;
            TRAIN_CNT <= '0;
            TXD_DATA  <= {LANES{TRAIN_PATTERN}};
            TX_VALID  <= 1'b1;
          end else begin
            TXD_DATA  <= '0;
            TX_VALID  <= 1'b0;
          end
        end

        TRAIN: begin
          if (TRAIN_CNT != 16'hFFFF)
            TRAIN_CNT <= TRAIN_CNT + 16'd1;
          if (!START) begin
            state    <= IDLE;
            TXD_DATA <= '0;
            TX_VALID <= 1'b0;
          end else if (ALGN_ERR) begin
            state    <= FAIL;
            TXD_DATA <= '0;
            TX_VALID <= 1'b0;
          end else if (ALGN_DONE && (TRAIN_CNT >= MIN_M1)) begin
            state    <= PRBS;
            lfsr     <= prbs_next;
            TXD_DATA <= {LANES{prbs_word}};
            TX_VALID <= 1'b1;
          end else if (TRAIN_CNT >= TIMEOUT) begin
            state    <= FAIL;
            TXD_DATA <= '0;
            TX_VALID <= 1'b0;
          end else begin
            TXD_DATA <= {LANES{TRAIN_PATTERN}};
            TX_VALID <= 1'b1;
          end
        end

        PRBS: begin
          if (!START) begin
            state    <= IDLE;
            TXD_DATA <= '0;
            TX_VALID <= 1'b0;
          end else begin
            lfsr     <= prbs_next;
            TXD_DATA <= {LANES{prbs_word}} ^ inj_mask;
            TX_VALID <= 1'b1;
          end
        end

        FAIL: begin
          TXD_DATA <= '0;
          TX_VALID <= 1'b0;
          if (!START)
            state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          TXD_DATA <= '0;
          TX_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
